// File: rtl/cello_tt_pkg.sv
// Shared types and helpers for the run-time loadable truth-table evaluator.
package cello_tt_pkg;

    typedef enum logic {
        SETTLING = 1'b0,
        STABLE   = 1'b1
    } state_e;

    localparam int GLITCH_W = 8;

    function automatic int tt_width(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/cello_settle_timer.sv
// Settle counter: cleared by restart, counts up and saturates at SETTLE-1.
// done is asserted while the count sits at SETTLE-1.
module cello_settle_timer #(
    parameter int SETTLE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic done
);

    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    if (SETTLE < 1) begin : g_bad_settle
        $error("cello_settle_timer: SETTLE must be >= 1");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/cello_tt_eval.sv
// N_IN-input truth-table evaluator that publishes only after SETTLE stable cycles.
// Optional aborted-settle counter enabled by defining CELLO_TT_GLITCH_CNT_EN.
module cello_tt_eval
    import cello_tt_pkg::*;
#(
    parameter int                          N_IN     = 4,
    parameter int                          SETTLE   = 8,
    parameter logic [tt_width(N_IN)-1:0]   TT_RESET = 16'h2C26
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_IN-1:0]             in_vec,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [tt_width(N_IN)-1:0]   cfg_tt,
    output logic                        out,
    output logic                        out_valid,
    output logic                        settling,
    output logic [GLITCH_W-1:0]         glitch_cnt
);

    localparam int TTW = tt_width(N_IN);

    if (N_IN < 1 || N_IN > 6) begin : g_bad_n_in
        $error("cello_tt_eval: N_IN must be in 1..6");
    end

    state_e           state_q, state_d;
    logic [TTW-1:0]   tt_q, tt_d;
    logic [N_IN-1:0]  in_q, in_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic in_change;
    logic cfg_hs;
    logic restart;
    logic done;

    assign cfg_ready = (state_q == STABLE);
    assign in_change = (in_vec != in_q);
    assign cfg_hs    = cfg_valid & cfg_ready;
    assign restart   = in_change | cfg_hs;

    cello_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .done    (done)
    );

    // A restart captures inputs and table together; out keeps its last value.
    always_comb begin
        state_d     = state_q;
        tt_d        = tt_q;
        in_d        = in_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (restart) begin
            in_d        = in_vec;
            state_d     = SETTLING;
            out_valid_d = 1'b0;
            if (cfg_hs) begin
                tt_d = cfg_tt;
            end
        end else if (state_q == SETTLING && done) begin
            out_d       = tt_q[in_q];
            out_valid_d = 1'b1;
            state_d     = STABLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SETTLING;
            tt_q        <= TT_RESET;
            in_q        <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tt_q        <= tt_d;
            in_q        <= in_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign settling  = (state_q == SETTLING);

`ifdef CELLO_TT_GLITCH_CNT_EN
    // fresh_q marks the cycle right after a restart, when the settle count is still 0.
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                fresh_q, fresh_d;

    always_comb begin
        glitch_d = glitch_q;
        fresh_d  = restart;
        if (in_change && state_q == SETTLING && !fresh_q && glitch_q != '1) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
            fresh_q  <= 1'b1;
        end else begin
            glitch_q <= glitch_d;
            fresh_q  <= fresh_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = 8'd0;
`endif

endmodule
